pressure_check_sequencer: RTL and testbench
===========================================

Name: pressure_check_sequencer

Overview:
- Shares one combinational pressure analyzer among NUM_CH patient sensor channels.
- Each channel presents a 5-bit pressure code {a,b,c,d,e}. The block arbitrates round-robin, drives the winning code onto the shared analyzer inputs, and holds it SETTLE cycles.
- It then captures the analyzer's OK output and acknowledges the requester.
- It keeps per-channel consecutive-failure counts and raises sticky per-channel alarms for the health-check top level.

Parameters:
- NUM_CH, 4, number of requesting sensor channels (>=2).
- CH_W, 2, channel index width (>= clog2(NUM_CH)).
- SETTLE, 1, cycles the code is held on the analyzer before capture (>=1).
- FAIL_LIMIT, 3, consecutive failing evaluations that set a channel alarm (>=1).
- CNT_W, 4, failure counter width (FAIL_LIMIT < 2^CNT_W).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_CH  channel i has a reading pending; held until ack[i].
- code  in  5*NUM_CH  channel i code at [5i+4:5i], bit4=a..bit0=e; stable while req[i].
- ack  out  NUM_CH  one-hot, one-cycle pulse: channel's reading evaluated.
- result_ok  out  1  analyzer verdict for the acked reading (1 = normal).
- result_ch  out  CH_W  index of the acked channel.
- ana_code  out  5  registered drive to the shared analyzer inputs a..e.
- ana_ok  in  1  shared analyzer output F.
- alarm  out  NUM_CH  sticky per-channel alarm.
- alarm_clr  in  NUM_CH  per-channel alarm/counter clear, level-sampled.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low.
- Reset values: state IDLE, ack 0, result_ok 0, result_ch 0, ana_code 0, alarm 0, busy 0, rr pointer 0, all counters 0. Reset takes effect immediately, independent of clk.
- State IDLE:
  - Eligible set = req & ~ack; a channel is never re-granted in the cycle its ack is high.
  - If the eligible set is non-empty, grant the first eligible channel searching upward from the pointer, wrapping modulo NUM_CH.
  - On that edge: latch the channel index, load ana_code <= code[ch], load settle_cnt <= SETTLE-1, go to HOLD.
- State HOLD:
  - ana_code stable.
  - settle_cnt decrements each cycle; when it is 0, go to EVAL. HOLD therefore lasts exactly SETTLE cycles.
- State EVAL:
  - On the exit edge, sample ana_ok.
  - Assert ack[ch], result_ok=ana_ok and result_ch=ch for one cycle.
  - Pointer <= (ch+1) mod NUM_CH.
  - Go to IDLE.
- Latency and throughput:
  - ack is high in the cycle following the EVAL exit edge: SETTLE+2 edges after the grant-sampling edge, i.e. 3 for SETTLE=1.
  - Back-to-back throughput: one evaluation per SETTLE+2 cycles.
- ana_code holds its last value while IDLE. ack/result_ok/result_ch are all registered; result_ok/result_ch hold their value after ack drops.
- Failure counter, applied on the EVAL exit edge:
  - ana_ok=1: counter[ch] <= 0.
  - ana_ok=0: counter[ch] <= min(counter+1, FAIL_LIMIT).
  - alarm[ch] is set when the updated counter equals FAIL_LIMIT.
  - Further failures keep the counter saturated at FAIL_LIMIT.
  - An OK result clears the counter but does not clear alarm.
- alarm_clr[i] (any state): alarm[i] <= 0 and counter[i] <= 0 on the next edge.
  - Exception: if channel i is being evaluated on that same edge, the evaluation update is applied and the clear is ignored. Alarm set wins.
- Requests arriving during HOLD/EVAL wait; there is no preemption. req dropping mid-service does not abort; ack is still issued.
- Reset mid-operation (HOLD/EVAL): no ack is issued for the aborted reading. After release, still-asserted requests are re-arbitrated from pointer 0.
- Bench analyzer model: ana_ok = ~(a ^ b). So code 5'b11000 -> ok=1 and 5'b10111 -> ok=0.

Test Plan:
- Single channel: after reset, req=4'b0100, code2=5'b11000 -> ana_code=5'b11000 from the next cycle. ack=4'b0100, result_ok=1, result_ch=2 for exactly one cycle, 3 edges after the grant. alarm=0, busy low again with ack.
- Fairness: req=4'b1111 held continuously -> ack sequence 0,1,2,3,0, spaced 3 cycles apart. No channel is acked twice within any 4 consecutive acks.
- Alarm threshold:
  - ch1 codes fail, fail, ok, fail, fail -> alarm[1]=0 throughout.
  - A third consecutive fail -> alarm[1]=1 in the cycle ack[1] rises.
  - A subsequent ok -> alarm[1] stays 1.
- Clear collision: alarm_clr[1] asserted on the edge of a failing ch1 eval at the limit -> alarm[1] stays 1. alarm_clr[1] alone next cycle -> alarm[1]=0, counter 0 (needs 3 new fails to re-alarm).
- Async reset mid-HOLD (SETTLE=4): rst_n pulsed low between edges -> all outputs 0 immediately with no clock edge and no ack. After release, held req[3] is served, ack 6 edges after the grant.
- Held request after ack: req[0] kept high in the ack cycle with all other req low -> no grant in that cycle. Re-grant of ch0 on the following edge, second ack 3 edges later.

Source files
------------

// File: rtl/pressure_check_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pressure_check_sequencer
// Brief    : Round-robin sharing of one combinational pressure analyzer among
//            NUM_CH sensor channels, with per-channel failure counting/alarms.
// Revision : 1.0 - initial release
// ============================================================================
module pressure_check_sequencer #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int SETTLE     = 1,
    parameter int FAIL_LIMIT = 3,
    parameter int CNT_W      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   req,
    input  logic [5*NUM_CH-1:0] code,
    output logic [NUM_CH-1:0]   ack,
    output logic                result_ok,
    output logic [CH_W-1:0]     result_ch,
    output logic [4:0]          ana_code,
    input  logic                ana_ok,
    output logic [NUM_CH-1:0]   alarm,
    input  logic [NUM_CH-1:0]   alarm_clr,
    output logic                busy
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_EVAL = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CH_W-1:0]    r_ch;
    logic [CH_W-1:0]    r_ptr;
    logic [SET_W-1:0]   r_settle;
    logic [NUM_CH-1:0]  r_ack;
    logic               r_result_ok;
    logic [CH_W-1:0]    r_result_ch;
    logic [4:0]         r_ana_code;
    logic [NUM_CH-1:0]  r_alarm;
    logic [CNT_W-1:0]   r_cnt [NUM_CH];

    logic [NUM_CH-1:0]  w_eligible;
    logic               w_grant_vld;
    logic [CH_W-1:0]    w_grant_ch;
    logic [4:0]         w_grant_code;
    logic [CH_W:0]      w_sum;
    logic [CH_W-1:0]    w_idx;
    logic               w_grant;
    logic               w_eval;
    logic [CH_W-1:0]    w_ptr_nxt;

    // Descending scan so the candidate closest above the pointer is kept last.
    always_comb begin
        w_eligible   = req & ~r_ack;
        w_grant_vld  = 1'b0;
        w_grant_ch   = '0;
        w_sum        = '0;
        w_idx        = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (CH_W+1)'(k);
            if (w_sum >= (CH_W+1)'(NUM_CH)) begin
                w_sum = w_sum - (CH_W+1)'(NUM_CH);
            end
            w_idx = w_sum[CH_W-1:0];
            if (w_eligible[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_ch  = w_idx;
            end
        end
    end

    always_comb begin
        w_grant_code = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant_ch == CH_W'(i)) begin
                w_grant_code = code[5*i +: 5];
            end
        end
    end

    assign w_grant   = (r_state == ST_IDLE) && w_grant_vld;
    assign w_eval    = (r_state == ST_EVAL);
    assign w_ptr_nxt = (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + CH_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_grant_vld)      w_state_nxt = ST_HOLD;
            ST_HOLD: if (r_settle == '0)   w_state_nxt = ST_EVAL;
            ST_EVAL:                       w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch        <= '0;
            r_ptr       <= '0;
            r_settle    <= '0;
            r_ack       <= '0;
            r_result_ok <= 1'b0;
            r_result_ch <= '0;
            r_ana_code  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_ack[i] <= w_eval && (r_ch == CH_W'(i));
            end
            if (w_grant) begin
                r_ch       <= w_grant_ch;
                r_ana_code <= w_grant_code;
                r_settle   <= SET_W'(SETTLE - 1);
            end else if ((r_state == ST_HOLD) && (r_settle != '0)) begin
                r_settle <= r_settle - SET_W'(1);
            end
            if (w_eval) begin
                r_result_ok <= ana_ok;
                r_result_ch <= r_ch;
                r_ptr       <= w_ptr_nxt;
            end
        end
    end

    // The evaluation update of a channel takes priority over its clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alarm <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_eval && (r_ch == CH_W'(i))) begin
                    if (ana_ok) begin
                        r_cnt[i] <= '0;
                    end else begin
                        if (r_cnt[i] != CNT_W'(FAIL_LIMIT)) begin
                            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                        end
                        if (r_cnt[i] >= CNT_W'(FAIL_LIMIT - 1)) begin
                            r_alarm[i] <= 1'b1;
                        end
                    end
                end else if (alarm_clr[i]) begin
                    r_cnt[i]   <= '0;
                    r_alarm[i] <= 1'b0;
                end
            end
        end
    end

    assign ack       = r_ack;
    assign result_ok = r_result_ok;
    assign result_ch = r_result_ch;
    assign ana_code  = r_ana_code;
    assign alarm     = r_alarm;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pressure_check_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pressure_check_sequencer
// Brief    : Scoreboard bench: directed scenarios plus randomized request bursts
//            against a transaction-level round-robin / alarm reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pressure_check_sequencer;

    localparam int N  = 4;
    localparam int FL = 3;
    localparam logic [4:0] C_OK   = 5'b11000;
    localparam logic [4:0] C_FAIL = 5'b10111;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req = '0;
    logic [5*N-1:0] code = '0;
    logic [N-1:0]   ack;
    logic           result_ok;
    logic [1:0]     result_ch;
    logic [4:0]     ana_code;
    logic           ana_ok;
    logic [N-1:0]   alarm;
    logic [N-1:0]   alarm_clr = '0;
    logic           busy;

    always #5 clk = ~clk;

    assign ana_ok = ~(ana_code[4] ^ ana_code[3]);

    pressure_check_sequencer #(
        .NUM_CH(N), .CH_W(2), .SETTLE(1), .FAIL_LIMIT(FL), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .code(code), .ack(ack),
        .result_ok(result_ok), .result_ch(result_ch), .ana_code(ana_code),
        .ana_ok(ana_ok), .alarm(alarm), .alarm_clr(alarm_clr), .busy(busy)
    );

    typedef struct {
        int         ch;
        logic       ok;
        logic [N-1:0] alarm;
    } exp_t;

    exp_t         sb[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           m_cnt [N];
    logic [N-1:0] m_alarm;
    int           m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_alarm = '0;
        m_ptr   = 0;
    endfunction

    function automatic void model_eval(input int ch, input logic [4:0] c);
        exp_t e;
        logic ok;
        ok = (c[4] == c[3]);
        if (ok) m_cnt[ch] = 0;
        else if (m_cnt[ch] < FL) m_cnt[ch]++;
        if (!ok && m_cnt[ch] == FL) m_alarm[ch] = 1'b1;
        m_ptr   = (ch + 1) % N;
        e.ch    = ch;
        e.ok    = ok;
        e.alarm = m_alarm;
        sb.push_back(e);
    endfunction

    // All requests of a burst are raised together, so service order is the
    // set sorted by distance above the pointer.
    function automatic void model_burst(input logic [N-1:0] set);
        int start;
        start = m_ptr;
        for (int k = 0; k < N; k++) begin
            if (set[(start + k) % N]) model_eval((start + k) % N, code[5*((start + k) % N) +: 5]);
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        logic [N-1:0] oh;
        if (rst_n && ack !== '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(ack), 32'h0);
            end else begin
                e  = sb.pop_front();
                oh = '0;
                oh[e.ch] = 1'b1;
                chk("ack_onehot", 32'(ack), 32'(oh));
                chk("result_ch", 32'(result_ch), 32'(e.ch));
                chk("result_ok", 32'(result_ok), 32'(e.ok));
                chk("alarm_vec", 32'(alarm), 32'(e.alarm));
            end
        end
    end

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ack == '0 && n < 40);
        if (ack == '0) chk("ack_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while ((busy || ack != '0) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk("idle_timeout", 32'h1, 32'h0);
    endtask

    task automatic issue(input int ch, input logic [4:0] c);
        int n;
        wait_idle();
        code[5*ch +: 5] = c;
        req[ch] = 1'b1;
        model_eval(ch, c);
        wait_ack(n);
        chk("latency", 32'(n), 32'd3);
        req[ch] = 1'b0;
    endtask

    task automatic do_reset();
        req = '0;
        alarm_clr = '0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin : driver
        int n;
        logic [N-1:0] set, pend, clr;
        int guard;

        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_result_ok", 32'(result_ok), 32'h0);
        chk("rst_result_ch", 32'(result_ch), 32'h0);
        chk("rst_ana_code", 32'(ana_code), 32'h0);
        chk("rst_alarm", 32'(alarm), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single channel
        wait_idle();
        code[10 +: 5] = C_OK;
        req = 4'b0100;
        model_eval(2, C_OK);
        @(posedge clk); #1;
        chk("single_ana_code", 32'(ana_code), 32'(C_OK));
        chk("single_busy", 32'(busy), 32'h1);
        chk("single_no_early_ack", 32'(ack), 32'h0);
        wait_ack(n);
        chk("single_latency", 32'(n + 1), 32'd3);
        chk("single_busy_low", 32'(busy), 32'h0);
        req = '0;
        @(posedge clk); #1;
        chk("single_ack_pulse", 32'(ack), 32'h0);
        chk("single_hold_ok", 32'(result_ok), 32'h1);
        chk("single_hold_code", 32'(ana_code), 32'(C_OK));

        // Fairness from pointer 0
        do_reset();
        for (int i = 0; i < N; i++) code[5*i +: 5] = 5'($urandom);
        model_burst(4'b1111);
        model_eval(0, code[4:0]);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(n);
            chk("fair_spacing", 32'(n), 32'd3);
            chk("fair_order", 32'(ack), 32'(4'b0001 << (k % N)));
        end
        req = '0;

        // Alarm threshold on ch1
        issue(1, C_FAIL);
        issue(1, C_FAIL);
        issue(1, C_OK);
        issue(1, C_FAIL);
        issue(1, C_FAIL);
        issue(1, C_FAIL);
        chk("alarm_set", 32'(alarm[1]), 32'h1);
        issue(1, C_OK);
        chk("alarm_sticky", 32'(alarm[1]), 32'h1);

        // Clear colliding with a limit-reaching failing eval
        issue(1, C_FAIL);
        issue(1, C_FAIL);
        wait_idle();
        code[5 +: 5] = C_FAIL;
        req[1] = 1'b1;
        model_eval(1, C_FAIL);
        @(posedge clk); #1;
        @(posedge clk); #1;
        alarm_clr[1] = 1'b1;
        @(posedge clk); #1;
        chk("collide_ack", 32'(ack), 32'h2);
        chk("collide_alarm", 32'(alarm[1]), 32'h1);
        req[1] = 1'b0;
        @(posedge clk); #1;
        alarm_clr = '0;
        m_alarm[1] = 1'b0;
        m_cnt[1] = 0;
        chk("clear_alarm", 32'(alarm[1]), 32'h0);
        issue(1, C_FAIL);
        issue(1, C_FAIL);
        chk("clear_cnt_zero", 32'(alarm[1]), 32'h0);
        issue(1, C_FAIL);

        // Held request after ack
        wait_idle();
        code[0 +: 5] = C_OK;
        req[0] = 1'b1;
        model_eval(0, C_OK);
        model_eval(0, C_OK);
        wait_ack(n);
        chk("held_first_latency", 32'(n), 32'd3);
        @(posedge clk); #1;
        chk("held_no_regrant", 32'(busy), 32'h0);
        @(posedge clk); #1;
        chk("held_regrant", 32'(busy), 32'h1);
        wait_ack(n);
        chk("held_second_latency", 32'(n + 1), 32'd3);
        req[0] = 1'b0;

        // Async reset in the middle of HOLD
        issue(1, C_FAIL);
        wait_idle();
        code[15 +: 5] = C_FAIL;
        req[3] = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ack", 32'(ack), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_ana_code", 32'(ana_code), 32'h0);
        chk("arst_alarm", 32'(alarm), 32'h0);
        chk("arst_result_ok", 32'(result_ok), 32'h0);
        chk("arst_result_ch", 32'(result_ch), 32'h0);
        #1 rst_n = 1'b1;
        model_reset();
        model_eval(3, C_FAIL);
        wait_ack(n);
        chk("arst_reserve_latency", 32'(n), 32'd3);
        req = '0;

        // Randomized bursts with occasional idle-time clears
        for (int b = 0; b < 40; b++) begin
            wait_idle();
            if ($urandom_range(0, 3) == 0) begin
                clr = N'($urandom);
                alarm_clr = clr;
                @(posedge clk); #1;
                alarm_clr = '0;
                for (int i = 0; i < N; i++) begin
                    if (clr[i]) begin
                        m_cnt[i] = 0;
                        m_alarm[i] = 1'b0;
                    end
                end
                chk("rand_clear", 32'(alarm), 32'(m_alarm));
                @(negedge clk);
            end
            set = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (set[i]) code[5*i +: 5] = 5'($urandom);
            end
            model_burst(set);
            req  = set;
            pend = set;
            guard = 0;
            while (pend != '0 && guard < 200) begin
                @(posedge clk); #1;
                guard++;
                pend = pend & ~ack;
                req  = req & ~ack;
            end
            if (pend != '0) chk("burst_timeout", 32'(pend), 32'h0);
            req = '0;
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_drain", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
